// File: rtl/aesl_deadlock_report_unit.sv
// Deadlock report arbiter: picks an origin process, launches a report token,
// tracks the processes it visits until the loop closes, and holds one report.
module aesl_deadlock_report_unit #(
  parameter int PROC_NUM = 4,
  parameter int ID_W     = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_active_vec,
  input  logic                report_ack,
  output logic [PROC_NUM-1:0] origin,
  output logic [PROC_NUM-1:0] token_clear,
  output logic                report_vld,
  output logic [ID_W-1:0]     report_origin,
  output logic [PROC_NUM-1:0] report_path,
  output logic [15:0]         report_len,
  output logic                deadlock_flag
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ORIGIN = 3'd1,
    ST_WALK   = 3'd2,
    ST_REPORT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] CNT_MAX      = 16'hFFFF;

  // Lowest set index wins when several detectors fire together.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] vec);
    lowest_idx = {ID_W{1'b0}};
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (vec[i]) lowest_idx = ID_W'(i);
    end
  endfunction

  function automatic logic [PROC_NUM-1:0] one_hot(input logic [ID_W-1:0] idx);
    one_hot = {{(PROC_NUM-1){1'b0}}, 1'b1} << idx;
  endfunction

  state_t              state_r;
  state_t              state_s;
  logic [ID_W-1:0]     origin_idx_r;
  logic [PROC_NUM-1:0] path_r;
  logic [15:0]         cnt_r;
  logic [15:0]         cnt_inc_s;
  logic                closure_s;

  // Next-state decode and the combinational token_clear strobe.
  always_comb begin
    state_s     = state_r;
    token_clear = {PROC_NUM{1'b0}};
    closure_s   = dl_detect_vec[origin_idx_r] & token_active_vec[origin_idx_r];
    cnt_inc_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 16'd1;
    case (state_r)
      ST_IDLE: begin
        if (|dl_detect_vec) state_s = ST_ORIGIN;
        else                state_s = ST_IDLE;
      end
      ST_ORIGIN: state_s = ST_WALK;
      ST_WALK: begin
        // Closure takes priority over a coincident timeout.
        if (closure_s) begin
          state_s     = ST_REPORT;
          token_clear = one_hot(origin_idx_r);
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WALK;
        end
      end
      ST_REPORT: begin
        if (report_ack) state_s = ST_DONE;
        else            state_s = ST_REPORT;
      end
      ST_DONE: state_s = ST_DONE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, walk bookkeeping and registered report outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      origin_idx_r  <= {ID_W{1'b0}};
      path_r        <= {PROC_NUM{1'b0}};
      cnt_r         <= 16'd0;
      origin        <= {PROC_NUM{1'b0}};
      report_vld    <= 1'b0;
      report_origin <= {ID_W{1'b0}};
      report_path   <= {PROC_NUM{1'b0}};
      report_len    <= 16'd0;
      deadlock_flag <= 1'b0;
    end else begin
      state_r    <= state_s;
      origin     <= {PROC_NUM{1'b0}};
      report_vld <= (state_s == ST_REPORT);
      case (state_r)
        ST_IDLE: begin
          if (|dl_detect_vec) begin
            origin_idx_r <= lowest_idx(dl_detect_vec);
            origin       <= one_hot(lowest_idx(dl_detect_vec));
          end
        end
        ST_ORIGIN: begin
          path_r <= one_hot(origin_idx_r);
          cnt_r  <= 16'd0;
        end
        ST_WALK: begin
          path_r <= path_r | token_active_vec;
          cnt_r  <= cnt_inc_s;
          if (closure_s) begin
            report_len    <= cnt_inc_s;
            report_path   <= path_r | token_active_vec;
            report_origin <= origin_idx_r;
            deadlock_flag <= 1'b1;
          end
        end
        ST_REPORT: ;
        ST_DONE:   ;
        default:   ;
      endcase
    end
  end

endmodule
